// File: rtl/switch_confirm_input.sv
// Confirm-button debouncer and DIP-switch snapshot register for the IO mux.
// A debounced press latches the switches and holds them pending until the CPU acknowledges them.
module switch_confirm_input #(
    parameter int          DB_CYCLES = 100000,
    parameter logic [13:0] RD_ADDR   = 14'h3C70,
    parameter logic [13:0] ACK_ADDR  = 14'h3C80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_i,
    input  logic        btn_confirm_i,
    input  logic        ioRead_i,
    input  logic        ioWrite_i,
    input  logic [13:0] addr_i,
    output logic [15:0] io_rdata_o,
    output logic        confirm_o,
    output logic        overrun_o
);

    localparam int                 CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);

    typedef enum logic {DB_STABLE = 1'b0, DB_COUNTING = 1'b1} db_state_t;
    typedef enum logic {P_IDLE = 1'b0, P_PENDING = 1'b1} pend_state_t;

    logic             btn_meta_r;
    logic             btn_sync_r;
    logic [15:0]      sw_meta_r;
    logic [15:0]      sw_sync_r;
    db_state_t        db_state_r;
    logic             stable_r;
    logic             stable_d_r;
    logic [CNT_W-1:0] cnt_r;
    pend_state_t      pend_state_r;
    logic             press_s;
    logic             ack_s;

    // Two-flop synchronisers for the button and every switch bit
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            sw_meta_r  <= 16'h0000;
            sw_sync_r  <= 16'h0000;
        end else begin
            btn_meta_r <= btn_confirm_i;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw_i;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Debounce FSM: a new level must persist DB_CYCLES consecutive cycles to be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            db_state_r <= DB_STABLE;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
        end else begin
            stable_d_r <= stable_r;
            case (db_state_r)
                DB_STABLE: begin
                    if (btn_sync_r != stable_r) begin
                        db_state_r <= DB_COUNTING;
                        cnt_r      <= CNT_ONE;
                    end else begin
                        cnt_r      <= CNT_ZERO;
                    end
                end
                DB_COUNTING: begin
                    if (btn_sync_r == stable_r) begin
                        db_state_r <= DB_STABLE;
                        cnt_r      <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        stable_r   <= btn_sync_r;
                        db_state_r <= DB_STABLE;
                        cnt_r      <= CNT_ZERO;
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    db_state_r <= DB_STABLE;
                    cnt_r      <= CNT_ZERO;
                end
            endcase
        end
    end

    // Rising edge of the accepted level and CPU acknowledge decode
    always_comb begin
        press_s = stable_r & ~stable_d_r;
        ack_s   = (ioRead_i & (addr_i == RD_ADDR)) | (ioWrite_i & (addr_i == ACK_ADDR));
    end

    // Pending FSM: a press always wins over a same-cycle acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_state_r <= P_IDLE;
            io_rdata_o   <= 16'h0000;
            confirm_o    <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            case (pend_state_r)
                P_IDLE: begin
                    if (press_s) begin
                        io_rdata_o   <= sw_sync_r;
                        confirm_o    <= 1'b1;
                        pend_state_r <= P_PENDING;
                    end else begin
                        confirm_o    <= 1'b0;
                    end
                end
                P_PENDING: begin
                    if (press_s) begin
                        io_rdata_o <= sw_sync_r;
                        confirm_o  <= 1'b1;
                        if (!ack_s) begin
                            overrun_o <= 1'b1;
                        end
                    end else if (ack_s) begin
                        confirm_o    <= 1'b0;
                        pend_state_r <= P_IDLE;
                    end else begin
                        confirm_o    <= 1'b1;
                    end
                end
                default: begin
                    pend_state_r <= P_IDLE;
                    confirm_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/switch_confirm_input.md
# switch_confirm_input

Debounced switch/button input block. It sits directly upstream of the memory/IO mux and supplies its 16-bit IO read data and its `confirm` flag. It synchronises and debounces the confirm push-button and snapshots the 16 DIP switches on each debounced press. The snapshot is held as a pending value until the CPU acknowledges it through an IO access.

## Interface
Parameters:
- `DB_CYCLES`, default 100000: consecutive stable cycles required before a button level change is accepted; legal range ≥2.
- `RD_ADDR`, default 14'h3C70: IO read address of the switch snapshot; a read here acknowledges the pending value.
- `ACK_ADDR`, default 14'h3C80: IO write address that also acknowledges the pending value.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: reset, synchronous and active-high.
- `sw_i`  in  16: raw asynchronous switch levels.
- `btn_confirm_i`  in  1: raw asynchronous confirm button, 1 = pressed.
- `ioRead_i`  in  1: CPU IO read strobe, 1 cycle per access.
- `ioWrite_i`  in  1: CPU IO write strobe, 1 cycle per access.
- `addr_i`  in  14: CPU IO address.
- `io_rdata_o`  out  16: registered switch snapshot; feeds the mux IO read-data input.
- `confirm_o`  out  1: registered pending flag; feeds the mux confirm input.
- `overrun_o`  out  1: sticky flag, 1 = a press arrived while a value was still pending.

## Operation
- **Synchroniser:** 2-flop synchroniser on `btn_confirm_i` and on each bit of `sw_i`. Only the synchronised copies are used downstream.
- **Debounce FSM, states STABLE and COUNTING:**
  - `stable` register holds the accepted button level. `cnt` is `$clog2(DB_CYCLES+1)` bits wide.
  - STABLE: if the synchronised button equals `stable`, hold `cnt`=0. Otherwise go to COUNTING with `cnt`=1.
  - COUNTING: if the synchronised button equals `stable` (bounce), return to STABLE with `cnt`=0.
  - COUNTING, input still differs and `cnt`==DB_CYCLES-1: set `stable` to the new level, `cnt`=0, go to STABLE.
  - COUNTING, input still differs otherwise: increment `cnt`.
- **Press event:** `press` = `stable` & ~`stable_d`, where `stable_d` is `stable` delayed by 1 cycle. A release never generates an event.
- **Acknowledge:** `ack` = (`ioRead_i` & `addr_i`==RD_ADDR) | (`ioWrite_i` & `addr_i`==ACK_ADDR).
- **Pending FSM, states IDLE and PENDING:**
  - IDLE + `press`: `io_rdata_o` takes the synchronised switches, `confirm_o` goes to 1, go to PENDING.
  - PENDING + `ack` without `press`: `confirm_o` goes to 0, go to IDLE. `io_rdata_o` holds its value.
  - PENDING + `press` (with or without `ack`): `io_rdata_o` is overwritten, `confirm_o` stays 1, and `overrun_o` is set only if `ack` is absent.
  - IDLE + `ack`: no effect.
- **Overrun:** `overrun_o` is cleared only by `rst`.
- **Read data:** `io_rdata_o` is never cleared by `ack`. A read always returns the last snapshot.

## Timing
- **Reset values:** all outputs 0; sync flops, `stable`, `stable_d` and `cnt` all 0; both FSMs in their first state.
- **Press latency:** if `btn_confirm_i` is high at posedge N and stays high:
  - `stable` goes to 1 after edge N+1+DB_CYCLES.
  - `confirm_o` and `io_rdata_o` update at edge N+2+DB_CYCLES.
- **Snapshot contents:** the captured value is `sw_i` as sampled 2 edges before the capture edge.
- **Ack latency:** `ack` asserted in the cycle before edge M gives `confirm_o`=0 after edge M. The read in that same cycle sees the pre-edge `io_rdata_o`.
- **Simultaneous `ack` and `press` in one cycle:** the press wins. `confirm_o` stays 1, new data is loaded, `overrun_o` is unchanged.
- **Reset mid-operation:** reset during COUNTING or PENDING drops everything to reset values at that edge. A button still held after reset needs a full DB_CYCLES debounce and then produces a press.
- **Bounce shorter than DB_CYCLES:** produces no event.

## Test plan
All scenarios run with `DB_CYCLES`=4.
- **Reset:** hold `rst` for 3 cycles with the button and switches toggling → `io_rdata_o`=0, `confirm_o`=0, `overrun_o`=0 throughout reset.
- **Clean press:** `sw_i`=16'hA5C3, button high from edge 10 → `confirm_o`=1 and `io_rdata_o`=16'hA5C3 after edge 16, and not before.
- **Bounce:** button pulses high for 3 cycles, low for 1, then high steadily from edge 20 → exactly one press, with `confirm_o` rising after edge 26.
- **Ack by read:** in PENDING, `ioRead_i`=1 and `addr_i`=14'h3C70 for 1 cycle → `confirm_o`=0 after that edge, `io_rdata_o` unchanged.
- **Ack by write:** `ioWrite_i`=1 and `addr_i`=14'h3C80 also clears `confirm_o`. A read at 14'h3C71 does not.
- **Overrun and collision:**
  - Second debounced press while PENDING with `sw_i`=16'h1234 → `io_rdata_o`=16'h1234, `overrun_o`=1.
  - A press coinciding with `ack` → `confirm_o` stays 1, `overrun_o` unchanged.
